// File: rtl/sliding_window_sequencer.sv
// Frame sequencer for one sliding_window: accepts a pixel stream, tracks column/row,
// and flags/holds complete in-image windows until the downstream consumer takes them.
module sliding_window_sequencer #(
   parameter int K        = 3,
   parameter int CW       = 10,
   parameter int NUM_XRES = 5,
   parameter logic [NUM_XRES-1:0][CW-1:0] XRES = {CW'(8), CW'(4), CW'(64), CW'(32), CW'(16)}
) (
   input  logic          clock,
   input  logic          clock_sreset,
   input  logic          start,
   input  logic [2:0]    cfg_xres_select,
   input  logic [CW-1:0] cfg_yres,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          data_shift,
   output logic [2:0]    xres_select,
   output logic          window_valid,
   input  logic          window_ready,
   output logic [CW-1:0] window_x,
   output logic [CW-1:0] window_y,
   output logic          busy,
   output logic          frame_done,
   output logic          cfg_error
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_FLUSH  = 2'd2;

   localparam logic [CW-1:0] ONE = CW'(1);
   localparam logic [CW-1:0] KW  = CW'(K);
   localparam logic [CW-1:0] KM1 = CW'(K - 1);

   logic [1:0]    state_q, state_d;
   logic [2:0]    xsel_q, xsel_d;
   logic [CW-1:0] xres_q, xres_d, yres_q, yres_d;
   logic [CW-1:0] col_q, col_d, row_q, row_d;
   logic [CW-1:0] wx_q, wx_d, wy_q, wy_d;
   logic          wv_q, wv_d, done_q, done_d, err_q, err_d;

   logic [CW-1:0] xres_lu;
   logic          sel_ok, cfg_ok, accept, last_col, last_px, qualify;

   // Out-of-range selects read back as width 0, which also fails the K check.
   always_comb begin
      xres_lu = '0;
      sel_ok  = 1'b0;
      for (int i = 0; i < NUM_XRES; i++) begin
         if (cfg_xres_select == 3'(i)) begin
            xres_lu = XRES[i];
            sel_ok  = 1'b1;
         end
      end
   end

   assign cfg_ok   = sel_ok && (cfg_yres >= KW) && (xres_lu >= KW);
   assign in_ready = (state_q == S_STREAM) && (!wv_q || window_ready);
   assign accept   = in_valid && in_ready;
   assign last_col = (col_q == xres_q - ONE);
   assign last_px  = last_col && (row_q == yres_q - ONE);
   assign qualify  = (col_q >= KM1) && (row_q >= KM1);

   always_comb begin
      state_d = state_q;
      xsel_d  = xsel_q;
      xres_d  = xres_q;
      yres_d  = yres_q;
      col_d   = col_q;
      row_d   = row_q;
      wx_d    = wx_q;
      wy_d    = wy_q;
      wv_d    = wv_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  state_d = S_STREAM;
                  xsel_d  = cfg_xres_select;
                  xres_d  = xres_lu;
                  yres_d  = cfg_yres;
                  col_d   = '0;
                  row_d   = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_STREAM: begin
            if (accept) begin
               if (last_col) begin
                  col_d = '0;
                  row_d = row_q + ONE;
               end else begin
                  col_d = col_q + ONE;
               end
               // Coordinates load only on qualifying pixels, so they never underflow.
               wv_d = qualify;
               if (qualify) begin
                  wx_d = col_q - KM1;
                  wy_d = row_q - KM1;
               end
               if (last_px) state_d = S_FLUSH;
            end else if (window_ready) begin
               wv_d = 1'b0;
            end
         end
         S_FLUSH: begin
            if (window_ready) begin
               wv_d    = 1'b0;
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clock_sreset) begin
         state_q <= S_IDLE;
         xsel_q  <= '0;
         xres_q  <= '0;
         yres_q  <= '0;
         col_q   <= '0;
         row_q   <= '0;
         wx_q    <= '0;
         wy_q    <= '0;
         wv_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         xsel_q  <= xsel_d;
         xres_q  <= xres_d;
         yres_q  <= yres_d;
         col_q   <= col_d;
         row_q   <= row_d;
         wx_q    <= wx_d;
         wy_q    <= wy_d;
         wv_q    <= wv_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign data_shift   = accept;
   assign xres_select  = xsel_q;
   assign window_valid = wv_q;
   assign window_x     = wx_q;
   assign window_y     = wy_q;
   assign busy         = (state_q != S_IDLE);
   assign frame_done   = done_q;
   assign cfg_error    = err_q;

endmodule

// File: tb/tb_sliding_window_sequencer.sv
// Directed bench for sliding_window_sequencer: window order/coordinates, backpressure,
// bursty input, illegal configs, mid-frame reset and the largest frame.
module tb_sliding_window_sequencer;
   localparam int K  = 3;
   localparam int CW = 10;

   logic          clock = 1'b0;
   logic          clock_sreset = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    cfg_xres_select = 3'd0;
   logic [CW-1:0] cfg_yres = '0;
   logic          in_valid = 1'b0;
   logic          window_ready = 1'b0;
   logic          in_ready, data_shift, window_valid, busy, frame_done, cfg_error;
   logic [2:0]    xres_select;
   logic [CW-1:0] window_x, window_y;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   sliding_window_sequencer #(.K(K), .CW(CW)) dut (
      .clock(clock), .clock_sreset(clock_sreset), .start(start),
      .cfg_xres_select(cfg_xres_select), .cfg_yres(cfg_yres),
      .in_valid(in_valid), .in_ready(in_ready), .data_shift(data_shift),
      .xres_select(xres_select), .window_valid(window_valid), .window_ready(window_ready),
      .window_x(window_x), .window_y(window_y), .busy(busy),
      .frame_done(frame_done), .cfg_error(cfg_error)
   );

   // Record every accepted window with the pixel-accept count and cycle at that moment.
   int cyc = 0;
   int acc_cnt = 0;
   int fd_cyc = -1;
   int wq_x[$], wq_y[$], wq_acc[$], wq_cyc[$];
   always @(negedge clock) begin
      cyc <= cyc + 1;
      if (window_valid && window_ready) begin
         wq_x.push_back(int'(window_x));
         wq_y.push_back(int'(window_y));
         wq_acc.push_back(acc_cnt);
         wq_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
      if (frame_done) fd_cyc <= cyc;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_data_shift"}, data_shift, 0);
      chk({tag, "_window_valid"}, window_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_cfg_error"}, cfg_error, 0);
      chk({tag, "_xres_select"}, xres_select, 0);
      chk({tag, "_window_x"}, window_x, 0);
      chk({tag, "_window_y"}, window_y, 0);
   endtask

   task automatic do_start(input logic [2:0] sel, input int y);
      @(posedge clock); #1;
      start = 1'b1;
      cfg_xres_select = sel;
      cfg_yres = CW'(y);
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic run_frame(input string tag, input logic [2:0] sel, input int xres, input int yres,
                            input bit bursty, input int sx, input int sy, input int stall_n,
                            input bit mid_start);
      int base, acc0, budget, c, cnt, hx, hy, n, errs, last;
      bit stalled, done;
      base = wq_x.size();
      acc0 = acc_cnt;
      do_start(sel, yres);
      chk({tag, "_busy_after_start"}, busy, 1);
      chk({tag, "_xres_select"}, xres_select, int'(sel));
      budget = 3 * xres * yres + 100;
      c = 0; cnt = 0; hx = 0; hy = 0; stalled = 0; done = 0;
      while (!done && c < budget) begin
         in_valid = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
         start = mid_start && (c == 5);
         if (start) cfg_xres_select = 3'd6;
         if (!stalled && stall_n > 0 && window_valid &&
             int'(window_x) == sx && int'(window_y) == sy) begin
            stalled = 1; cnt = stall_n; hx = sx; hy = sy;
         end
         window_ready = (cnt == 0);
         #1;
         if (cnt > 0) begin
            chk({tag, "_stall_in_ready"}, in_ready, 0);
            chk({tag, "_stall_data_shift"}, data_shift, 0);
            chk({tag, "_stall_window_valid"}, window_valid, 1);
            chk({tag, "_stall_window_x"}, window_x, hx);
            chk({tag, "_stall_window_y"}, window_y, hy);
            cnt--;
         end
         if (mid_start && c == 6) begin
            chk({tag, "_no_cfg_error"}, cfg_error, 0);
            chk({tag, "_still_busy"}, busy, 1);
         end
         @(posedge clock); #1;
         c++;
         if (frame_done) done = 1;
      end
      start = 1'b0;
      chk({tag, "_frame_done_seen"}, done, 1);
      chk({tag, "_busy_low_at_done"}, busy, 0);
      in_valid = 1'b0;
      window_ready = 1'b0;
      @(posedge clock); #1;
      chk({tag, "_frame_done_one_cycle"}, frame_done, 0);

      n = 0; errs = 0;
      for (int y = 0; y <= yres - K; y++) begin
         for (int x = 0; x <= xres - K; x++) begin
            if (base + n >= wq_x.size()) errs++;
            else if (wq_x[base + n] != x || wq_y[base + n] != y) errs++;
            n++;
         end
      end
      chk({tag, "_window_count"}, wq_x.size() - base, (xres - K + 1) * (yres - K + 1));
      chk({tag, "_window_seq_errs"}, errs, 0);
      if (wq_x.size() > base) begin
         last = wq_x.size() - 1;
         chk({tag, "_last_x"}, wq_x[last], xres - K);
         chk({tag, "_last_y"}, wq_y[last], yres - K);
         chk({tag, "_first_window_accepts"}, wq_acc[base] - acc0, (K - 1) * xres + K);
         chk({tag, "_done_latency"}, fd_cyc - wq_cyc[last], 1);
      end else begin
         chk({tag, "_no_windows"}, wq_x.size() - base, 1);
      end
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk_reset_vals("reset");
      clock_sreset = 1'b0;

      // Nominal: xres 8, yres 4 -> 12 windows, first at 19th accept, last (5,1).
      run_frame("nominal", 3'd4, 8, 4, 1'b0, 0, 0, 0, 1'b0);
      // Backpressure: consumer stalls 5 cycles on window (2,0).
      run_frame("backpressure", 3'd4, 8, 4, 1'b0, 2, 0, 5, 1'b0);
      // Bursty input stream.
      run_frame("bursty", 3'd4, 8, 4, 1'b1, 0, 0, 0, 1'b0);
      // Start (with an illegal select) issued mid-stream is ignored.
      run_frame("start_in_stream", 3'd4, 8, 4, 1'b0, 0, 0, 0, 1'b1);

      // Illegal configurations.
      do_start(3'd6, 4);
      chk("illegal_sel_cfg_error", cfg_error, 1);
      chk("illegal_sel_busy", busy, 0);
      @(posedge clock); #1;
      chk("illegal_sel_pulse_one_cycle", cfg_error, 0);
      do_start(3'd0, 2);
      chk("illegal_yres_cfg_error", cfg_error, 1);
      chk("illegal_yres_busy", busy, 0);

      // Reset after 10 accepted pixels.
      do_start(3'd4, 4);
      in_valid = 1'b1;
      window_ready = 1'b1;
      repeat (10) begin
         @(posedge clock); #1;
      end
      chk("pre_reset_busy", busy, 1);
      clock_sreset = 1'b1;
      @(posedge clock); #1;
      chk_reset_vals("midreset");
      clock_sreset = 1'b0;
      in_valid = 1'b0;
      window_ready = 1'b0;
      run_frame("after_reset", 3'd3, 4, 3, 1'b0, 0, 0, 0, 1'b0);

      // Largest frame: xres 64, yres 64 -> 3844 windows, last (61,61).
      run_frame("max", 3'd2, 64, 64, 1'b0, 0, 0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
